rx_word_packer: RTL and testbench

Parametrised receive-path packer that assembles a byte stream from the UART receive FIFO into NBYTES-wide words for the AXI4-Lite read side. It uses valid/ready handshakes on both sides, has a one-word output holding register so byte intake continues while a word waits, and can optionally flush partial words after an idle timeout. It sits between the RX FIFO and the register/AXI read logic.

---
 rtl/rx_word_packer.sv | 111 +++++++++++
 tb/tb_rx_word_packer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rx_word_packer.sv
// Packs an RX byte stream into little-endian NBYTES-wide words behind a one-word output slot.
// Optional idle-timeout flush of partial words is enabled with RX_PACK_TIMEOUT_EN.
module rx_word_packer #(
  parameter int NBYTES         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [8*NBYTES-1:0]         out_data,
  output logic [$clog2(NBYTES+1)-1:0] out_count
);

  localparam int            CW   = $clog2(NBYTES+1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES-1);
  localparam logic [CW-1:0] FULL = CW'(NBYTES);

  logic [8*NBYTES-1:0] pack_r;
  logic [8*NBYTES-1:0] pack_s;
  logic [CW-1:0]       cnt_r;
  logic                out_valid_r;
  logic [8*NBYTES-1:0] out_data_r;
  logic [CW-1:0]       out_count_r;

  logic last_s;
  logic accept_s;
  logic drain_s;
  logic complete_s;
  logic flush_s;

  assign last_s     = (cnt_r == LAST);
  // Only the word-completing byte can be refused, and only while the slot cannot empty.
  assign in_ready   = !(last_s && out_valid_r && !out_ready);
  assign accept_s   = in_valid && in_ready;
  assign drain_s    = out_valid_r && out_ready;
  assign complete_s = accept_s && last_s;

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_count  = out_count_r;

`ifdef RX_PACK_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TEXP = TW'(TIMEOUT_CYCLES-1);

  logic [TW-1:0] timer_r;
  logic          idle_s;

  // The TIMEOUT_CYCLES-th idle cycle is the expiry cycle; a byte arriving then wins.
  assign idle_s  = (cnt_r != '0) && !accept_s;
  assign flush_s = idle_s && (timer_r >= TEXP) && (!out_valid_r || out_ready);

  // Idle timer: clears on accept, empty word or flush; saturates while the slot is blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= '0;
    end else if (!idle_s || flush_s) begin
      timer_r <= '0;
    end else if (timer_r != TMAX) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  localparam logic TIMEOUT_OK = (TIMEOUT_CYCLES >= 1);

  assign flush_s = TIMEOUT_OK & 1'b0;
`endif

  // Pack register with the incoming byte merged at the current byte lane.
  always_comb begin
    pack_s = pack_r;
    if (accept_s) begin
      pack_s[8*cnt_r +: 8] = in_data;
    end else begin
      pack_s = pack_r;
    end
  end

  // Byte counter, pack register and output slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_r      <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_count_r <= '0;
    end else if (complete_s || flush_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= pack_s;
      out_count_r <= complete_s ? FULL : cnt_r;
      cnt_r       <= '0;
      pack_r      <= '0;
    end else begin
      if (drain_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s) begin
        pack_r <= pack_s;
        cnt_r  <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed scoreboard bench for rx_word_packer (NBYTES=4, TIMEOUT_CYCLES=8).
module tb_rx_word_packer;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   pulse_q[$];

  rx_word_packer #(.NBYTES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: sample at the falling edge, consume a word if handed over, return #1 after rise.
  task automatic tick(input bit chk_rdy, input logic exp_rdy);
    exp_t e;
    @(negedge clk);
    if (chk_rdy) chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      pulse_q.push_back(cyc);
      chk("word_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e.data});
        chk("out_count", {61'd0, out_count}, {61'd0, e.cnt});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick(1'b1, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_count", {61'd0, out_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick(1'b1, 1'b1);

    // Basic word, single-cycle valid pulse
    exp_q.push_back('{cnt: 3'd4, data: 32'h44332211});
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("basic_valid_set", {63'd0, out_valid}, 64'd1);
    tick(1'b1, 1'b1);
    chk("basic_valid_pulse", {63'd0, out_valid}, 64'd0);

    // Backpressure: stall on the completing byte, accept it on the draining edge
    out_ready = 1'b0;
    exp_q.push_back('{cnt: 3'd4, data: 32'h04030201});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07);
    in_valid = 1'b1;
    in_data  = 8'h08;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("stall_hold_data", {32'd0, out_data}, 64'h04030201);
    chk("stall_hold_count", {61'd0, out_count}, 64'd4);
    chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    exp_q.push_back('{cnt: 3'd4, data: 32'h08070605});
    tick(1'b1, 1'b1);
    in_valid = 1'b0;
    chk("reload_valid", {63'd0, out_valid}, 64'd1);
    chk("reload_data", {32'd0, out_data}, 64'h08070605);
    tick(1'b0, 1'b0);

    // Sustained stream: three words, four cycles apart
    pulse_q.delete();
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back('{cnt: 3'd4,
                        data: {8'(8'h23 + 8'(4*w)), 8'(8'h22 + 8'(4*w)),
                               8'(8'h21 + 8'(4*w)), 8'(8'h20 + 8'(4*w))}});
    end
    for (int i = 0; i < 12; i++) send(8'(8'h20 + 8'(i)));
    idle(2);
    chk("stream_words", pulse_q.size(), 64'd3);
    if (pulse_q.size() == 3) begin
      chk("stream_gap1", pulse_q[1] - pulse_q[0], 64'd4);
      chk("stream_gap2", pulse_q[2] - pulse_q[1], 64'd4);
    end

    // Reset mid-word discards the partial bytes
    send(8'hAA); send(8'hBB);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    tick(1'b0, 1'b0);
    rst = 1'b1;
    exp_q.push_back('{cnt: 3'd4, data: 32'h04030201});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);

`ifdef RX_PACK_TIMEOUT_EN
    // Idle flush of a two-byte partial word
    send(8'hC1); send(8'hC2);
    idle(7);
    chk("to_not_yet", {63'd0, out_valid}, 64'd0);
    exp_q.push_back('{cnt: 3'd2, data: 32'h0000C2C1});
    idle(1);
    chk("to_flush_valid", {63'd0, out_valid}, 64'd1);
    chk("to_flush_count", {61'd0, out_count}, 64'd2);
    idle(2);

    // Byte arriving on the expiry cycle beats the flush
    send(8'hD1);
    idle(7);
    send(8'hD2);
    chk("to_byte_wins", {63'd0, out_valid}, 64'd0);
    exp_q.push_back('{cnt: 3'd4, data: 32'hD4D3D2D1});
    send(8'hD3); send(8'hD4);
    idle(2);
`else
    // Without the timer a partial word waits indefinitely
    send(8'hE1);
    idle(20);
    chk("no_to_wait", {63'd0, out_valid}, 64'd0);
    exp_q.push_back('{cnt: 3'd4, data: 32'hE4E3E2E1});
    send(8'hE2); send(8'hE3); send(8'hE4);
    idle(2);
`endif

    chk("queue_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
